truth_table_prober: RTL

Sequencing stage that drives the three inputs of a 3-input Cello logic gate through all eight input combinations and collects the gate's response into an 8-bit truth-table word. It sits directly upstream of the gate, feeding `in1`/`in2`/`in3`, and also consumes the gate's `out`. The captured word is compared against the gate's hex name, e.g. 8'hA3, and a pass/fail verdict with a per-row mismatch mask is reported.

---
 rtl/truth_table_prober_if.sv | 29 ++
 rtl/truth_table_prober.sv | 125 ++++++++++++
 2 files changed

// File: rtl/truth_table_prober_if.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_prober_if
// Brief    : Control/status bundle between a test sequencer and the prober.
// Revision : 1.0 - initial release
// ============================================================================
interface truth_table_prober_if #(
    parameter int SETTLE_W = 8
);
    logic                start;
    logic                abort;
    logic [SETTLE_W-1:0] settle_cycles;
    logic                busy;
    logic                done;
    logic [7:0]          table_word;
    logic [7:0]          mismatch;
    logic                pass;

    modport master (
        output start, abort, settle_cycles,
        input  busy, done, table_word, mismatch, pass
    );

    modport slave (
        input  start, abort, settle_cycles,
        output busy, done, table_word, mismatch, pass
    );
endinterface
`default_nettype wire

// File: rtl/truth_table_prober.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_prober
// Brief    : Walks a 3-input gate through all 8 rows, captures its truth table
//            and reports pass/fail against EXPECTED with a per-row mask.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_prober #(
    parameter int         SETTLE_W = 8,
    parameter logic [7:0] EXPECTED = 8'hA3
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    truth_table_prober_if.slave  ctrl,
    input  wire logic            dut_out,
    output logic                 in1,
    output logic                 in2,
    output logic                 in3
);

    localparam int c_HOLD_W = SETTLE_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_sync1;
    logic                r_sync2;
    logic [2:0]          r_row;
    logic [c_HOLD_W-1:0] r_hold;
    logic [SETTLE_W-1:0] r_settle;
    logic [7:0]          r_table_word;
    logic [7:0]          r_mismatch;
    logic                r_pass;
    logic                w_capture;
    logic [7:0]          w_final_word;
    logic [c_HOLD_W-1:0] w_reload;

    assign w_capture = (r_state == ST_RUN) && (r_hold == '0);
    assign w_reload  = {2'b00, r_settle} + c_HOLD_W'(2);

    // Word as it will look once the current capture lands; used for the verdict.
    always_comb begin
        w_final_word                = r_table_word;
        w_final_word[3'd7 - r_row]  = r_sync2;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (ctrl.start) w_next = ST_RUN;
            ST_RUN: begin
                if (ctrl.abort)                     w_next = ST_IDLE;
                else if (w_capture && r_row == 3'd7) w_next = ST_FINISH;
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_row        <= 3'd0;
            r_hold       <= '0;
            r_settle     <= '0;
            r_table_word <= 8'h00;
            r_mismatch   <= 8'h00;
            r_pass       <= 1'b0;
        end else begin
            r_sync1 <= dut_out;
            r_sync2 <= r_sync1;
            case (r_state)
                ST_IDLE: begin
                    if (ctrl.start) begin
                        r_table_word <= 8'h00;
                        r_mismatch   <= 8'h00;
                        r_pass       <= 1'b0;
                        r_row        <= 3'd0;
                        r_settle     <= ctrl.settle_cycles;
                        r_hold       <= {2'b00, ctrl.settle_cycles} + c_HOLD_W'(2);
                    end
                end
                ST_RUN: begin
                    if (ctrl.abort) begin
                        r_row      <= 3'd0;
                        r_mismatch <= 8'h00;
                        r_pass     <= 1'b0;
                    end else if (w_capture) begin
                        // Row 7 wraps to 0, leaving the gate inputs at 000 in FINISH.
                        r_table_word <= w_final_word;
                        r_row        <= r_row + 3'd1;
                        r_hold       <= w_reload;
                        if (r_row == 3'd7) begin
                            r_mismatch <= w_final_word ^ EXPECTED;
                            r_pass     <= (w_final_word == EXPECTED);
                        end
                    end else begin
                        r_hold <= r_hold - c_HOLD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign {in1, in2, in3}  = r_row;
    assign ctrl.busy        = (r_state != ST_IDLE);
    assign ctrl.done        = (r_state == ST_FINISH);
    assign ctrl.table_word  = r_table_word;
    assign ctrl.mismatch    = r_mismatch;
    assign ctrl.pass        = r_pass;

endmodule
`default_nettype wire
